// File: rtl/tmc_spi_responder.sv
// tmc_spi_responder
// Device-side SPI endpoint that stands in for the stepper driver's
// configuration port. It accepts 40-bit mode-3 datagrams ({wr, addr[6:0],
// data[31:0]}), updates a small register file, and returns
// {status, read_buf}. read_buf holds the data selected by the previous read
// frame. A free-running microstep counter is advanced by step pulses, and an
// idle timer flags standstill. All asynchronous inputs are resynchronised
// into clk_in.
module tmc_spi_responder #(
    parameter int STANDSTILL_CYCLES = 1000000
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        sclk_in,
    input  logic        serial_in,
    input  logic        cs_n_in,
    input  logic        step_in,
    output logic        serial_out,
    output logic [31:0] gconf_out,
    output logic [31:0] ihold_irun_out,
    output logic [31:0] tpowerdown_out,
    output logic [31:0] tpwmthrs_out,
    output logic [31:0] chopconf_out,
    output logic [31:0] pwmconf_out,
    output logic        wr_strobe_out,
    output logic [6:0]  wr_addr_out
);

    localparam int IDLE_W = (STANDSTILL_CYCLES < 2) ? 1 : $clog2(STANDSTILL_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STANDSTILL_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

    localparam logic [6:0] ADDR_GCONF      = 7'h00;
    localparam logic [6:0] ADDR_GSTAT      = 7'h01;
    localparam logic [6:0] ADDR_IHOLD_IRUN = 7'h10;
    localparam logic [6:0] ADDR_TPOWERDOWN = 7'h11;
    localparam logic [6:0] ADDR_TPWMTHRS   = 7'h13;
    localparam logic [6:0] ADDR_MSCNT      = 7'h6A;
    localparam logic [6:0] ADDR_CHOPCONF   = 7'h6C;
    localparam logic [6:0] ADDR_PWMCONF    = 7'h70;

    localparam logic [5:0] BITS_FRAME = 6'd40;
    localparam logic [5:0] BITS_SAT   = 6'd41;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // synchronisers and edge-detect history
    logic [1:0] sclk_sync_r;
    logic [1:0] mosi_sync_r;
    logic [1:0] cs_sync_r;
    logic [1:0] step_sync_r;
    logic       sclk_prev_r;
    logic       cs_prev_r;
    logic       step_prev_r;

    logic       sclk_rise_s;
    logic       sclk_fall_s;
    logic       cs_fall_s;
    logic       cs_rise_s;
    logic       step_rise_s;
    logic       mosi_s;

    // frame engine
    state_t     state_r;
    state_t     state_next_s;
    logic [39:0] rx_r;
    logic [39:0] rx_next_s;
    logic [38:0] tx_r;          // outgoing bits below the one on serial_out
    logic [38:0] tx_next_s;
    logic        serial_out_r;  // MSB of the outgoing shift word
    logic        serial_out_next_s;
    logic [5:0]  bit_cnt_r;
    logic [5:0]  bit_cnt_next_s;
    logic        commit_s;
    logic        frame_ok_s;

    // register file
    logic [31:0] gconf_r;
    logic [31:0] ihold_irun_r;
    logic [31:0] tpowerdown_r;
    logic [31:0] tpwmthrs_r;
    logic [31:0] chopconf_r;
    logic [31:0] pwmconf_r;
    logic        gstat_reset_r;
    logic        gstat_frame_err_r;
    logic [31:0] read_buf_r;
    logic        wr_strobe_r;
    logic [6:0]  wr_addr_r;
    logic        wr_hit_s;
    logic [31:0] read_value_s;

    // step tracking
    logic [9:0]        mscnt_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    logic              standstill_s;
    logic [7:0]        status_s;

    // Two-flop synchronisers plus one history flop per input for edge detection.
    // cs_n resets to the "selected" level so that a frame already in progress
    // when reset releases is never mistaken for a fresh falling edge.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sclk_sync_r <= 2'b11;
            mosi_sync_r <= 2'b00;
            cs_sync_r   <= 2'b00;
            step_sync_r <= 2'b00;
            sclk_prev_r <= 1'b1;
            cs_prev_r   <= 1'b0;
            step_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], sclk_in};
            mosi_sync_r <= {mosi_sync_r[0], serial_in};
            cs_sync_r   <= {cs_sync_r[0], cs_n_in};
            step_sync_r <= {step_sync_r[0], step_in};
            sclk_prev_r <= sclk_sync_r[1];
            cs_prev_r   <= cs_sync_r[1];
            step_prev_r <= step_sync_r[1];
        end
    end

    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r;
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_prev_r;
    assign cs_fall_s   = ~cs_sync_r[1] & cs_prev_r;
    assign cs_rise_s   = cs_sync_r[1] & ~cs_prev_r;
    assign step_rise_s = step_sync_r[1] & ~step_prev_r;
    assign mosi_s      = mosi_sync_r[1];

    assign standstill_s = (idle_cnt_r == IDLE_MAX);
    assign status_s     = {4'b0000, standstill_s, 1'b0, gstat_frame_err_r, gstat_reset_r};
    assign frame_ok_s   = (bit_cnt_r == BITS_FRAME);

    // Frame FSM next-state and shift-register datapath.
    always_comb begin
        state_next_s      = state_r;
        rx_next_s         = rx_r;
        tx_next_s         = tx_r;
        serial_out_next_s = serial_out_r;
        bit_cnt_next_s    = bit_cnt_r;
        commit_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                serial_out_next_s = 1'b0;
                if (cs_fall_s) begin
                    serial_out_next_s = status_s[7];
                    tx_next_s         = {status_s[6:0], read_buf_r};
                    bit_cnt_next_s    = 6'd0;
                    state_next_s      = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise_s) begin
                    rx_next_s = {rx_r[38:0], mosi_s};
                    if (bit_cnt_r != BITS_SAT) begin
                        bit_cnt_next_s = bit_cnt_r + 6'd1;
                    end else begin
                        bit_cnt_next_s = bit_cnt_r;
                    end
                end else begin
                    rx_next_s = rx_r;
                end
                // The first sclk fall precedes any data; the MSB is already out.
                if (sclk_fall_s && (bit_cnt_r != 6'd0)) begin
                    serial_out_next_s = tx_r[38];
                    tx_next_s         = {tx_r[37:0], 1'b0};
                end else begin
                    tx_next_s = tx_r;
                end
                if (cs_rise_s) begin
                    serial_out_next_s = 1'b0;
                    state_next_s      = ST_COMMIT;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                serial_out_next_s = 1'b0;
                commit_s          = 1'b1;
                state_next_s      = ST_IDLE;
            end
            default: begin
                serial_out_next_s = 1'b0;
                state_next_s      = ST_IDLE;
            end
        endcase
    end

    // Frame FSM state and shift registers.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r      <= ST_IDLE;
            rx_r         <= 40'd0;
            tx_r         <= 39'd0;
            serial_out_r <= 1'b0;
            bit_cnt_r    <= 6'd0;
        end else begin
            state_r      <= state_next_s;
            rx_r         <= rx_next_s;
            tx_r         <= tx_next_s;
            serial_out_r <= serial_out_next_s;
            bit_cnt_r    <= bit_cnt_next_s;
        end
    end

    // Decode whether the frame being committed is a write to a writable address.
    always_comb begin
        wr_hit_s = 1'b0;
        if (commit_s && frame_ok_s && rx_r[39]) begin
            case (rx_r[38:32])
                ADDR_GCONF, ADDR_GSTAT, ADDR_IHOLD_IRUN, ADDR_TPOWERDOWN,
                ADDR_TPWMTHRS, ADDR_CHOPCONF, ADDR_PWMCONF: wr_hit_s = 1'b1;
                default: wr_hit_s = 1'b0;
            endcase
        end else begin
            wr_hit_s = 1'b0;
        end
    end

    // Read-back multiplexer for the address carried in the received frame.
    always_comb begin
        read_value_s = 32'd0;
        case (rx_r[38:32])
            ADDR_GCONF:      read_value_s = gconf_r;
            ADDR_GSTAT:      read_value_s = {30'd0, gstat_frame_err_r, gstat_reset_r};
            ADDR_IHOLD_IRUN: read_value_s = ihold_irun_r;
            ADDR_TPOWERDOWN: read_value_s = tpowerdown_r;
            ADDR_TPWMTHRS:   read_value_s = tpwmthrs_r;
            ADDR_MSCNT:      read_value_s = {22'd0, mscnt_r};
            ADDR_CHOPCONF:   read_value_s = chopconf_r;
            ADDR_PWMCONF:    read_value_s = pwmconf_r;
            default:         read_value_s = 32'd0;
        endcase
    end

    // Register file, GSTAT flags, read buffer and write strobe, all updated in COMMIT.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            gconf_r           <= 32'd0;
            ihold_irun_r      <= 32'd0;
            tpowerdown_r      <= 32'd0;
            tpwmthrs_r        <= 32'd0;
            chopconf_r        <= 32'd0;
            pwmconf_r         <= 32'd0;
            gstat_reset_r     <= 1'b1;
            gstat_frame_err_r <= 1'b0;
            read_buf_r        <= 32'd0;
            wr_strobe_r       <= 1'b0;
            wr_addr_r         <= 7'd0;
        end else begin
            wr_strobe_r <= 1'b0;
            if (wr_hit_s) begin
                wr_strobe_r <= 1'b1;
                wr_addr_r   <= rx_r[38:32];
                case (rx_r[38:32])
                    ADDR_GCONF:      gconf_r      <= rx_r[31:0];
                    ADDR_IHOLD_IRUN: ihold_irun_r <= rx_r[31:0];
                    ADDR_TPOWERDOWN: tpowerdown_r <= rx_r[31:0];
                    ADDR_TPWMTHRS:   tpwmthrs_r   <= rx_r[31:0];
                    ADDR_CHOPCONF:   chopconf_r   <= rx_r[31:0];
                    ADDR_PWMCONF:    pwmconf_r    <= rx_r[31:0];
                    ADDR_GSTAT: begin
                        // write-1-to-clear
                        if (rx_r[0]) begin
                            gstat_reset_r <= 1'b0;
                        end
                        if (rx_r[1]) begin
                            gstat_frame_err_r <= 1'b0;
                        end
                    end
                    default: gconf_r <= gconf_r;
                endcase
            end
            if (commit_s && frame_ok_s && !rx_r[39]) begin
                read_buf_r <= read_value_s;
            end
            if (commit_s && !frame_ok_s) begin
                gstat_frame_err_r <= 1'b1;
            end
        end
    end

    // Microstep counter and standstill idle timer driven by step rising edges.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            mscnt_r    <= 10'd0;
            idle_cnt_r <= '0;
        end else begin
            if (step_rise_s) begin
                mscnt_r    <= mscnt_r + 10'd1;
                idle_cnt_r <= '0;
            end else if (idle_cnt_r != IDLE_MAX) begin
                idle_cnt_r <= idle_cnt_r + IDLE_ONE;
            end
        end
    end

    assign serial_out     = serial_out_r;
    assign gconf_out      = gconf_r;
    assign ihold_irun_out = ihold_irun_r;
    assign tpowerdown_out = tpowerdown_r;
    assign tpwmthrs_out   = tpwmthrs_r;
    assign chopconf_out   = chopconf_r;
    assign pwmconf_out    = pwmconf_r;
    assign wr_strobe_out  = wr_strobe_r;
    assign wr_addr_out    = wr_addr_r;

endmodule

// File: tb/tb_tmc_spi_responder.sv
// Directed self-checking bench for tmc_spi_responder.
module tb_tmc_spi_responder;

    localparam int SS   = 2000;
    localparam int HALF = 5;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        sclk_in;
    logic        serial_in;
    logic        cs_n_in;
    logic        step_in;
    logic        serial_out;
    logic [31:0] gconf_out, ihold_irun_out, tpowerdown_out, tpwmthrs_out, chopconf_out, pwmconf_out;
    logic        wr_strobe_out;
    logic [6:0]  wr_addr_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          step_model = 0;
    logic [39:0] rx_miso;
    int          sb_cnt;
    int          sb_cyc;
    logic [6:0]  sb_addr;
    logic [9:0]  exp_ms;

    tmc_spi_responder #(.STANDSTILL_CYCLES(SS)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .sclk_in(sclk_in),
        .serial_in(serial_in), .cs_n_in(cs_n_in), .step_in(step_in),
        .serial_out(serial_out), .gconf_out(gconf_out),
        .ihold_irun_out(ihold_irun_out), .tpowerdown_out(tpowerdown_out),
        .tpwmthrs_out(tpwmthrs_out), .chopconf_out(chopconf_out),
        .pwmconf_out(pwmconf_out), .wr_strobe_out(wr_strobe_out),
        .wr_addr_out(wr_addr_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic step_pulse();
        step_in = 1'b1;
        tick(3);
        step_in = 1'b0;
        tick(3);
        step_model++;
    endtask

    // One SPI frame of nbits clocks; optional reset pulse after bit rst_at.
    task automatic spi_frame(input logic [39:0] mosi, input int nbits, input int rst_at);
        rx_miso = 40'd0;
        sb_cnt  = 0;
        sb_cyc  = 0;
        sb_addr = 7'd0;
        cs_n_in = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            sclk_in = 1'b0;
            if (i < 40) serial_in = mosi[39-i];
            else serial_in = 1'b0;
            tick(HALF);
            rx_miso = {rx_miso[38:0], serial_out};
            sclk_in = 1'b1;
            tick(HALF);
            if (rst_at == i + 1) begin
                reset_n_in = 1'b0;
                tick(3);
                reset_n_in = 1'b1;
                step_model = 0;
            end
        end
        tick(3);
        cs_n_in   = 1'b1;
        serial_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (wr_strobe_out === 1'b1) begin
                sb_cnt++;
                if (sb_cyc == 0) sb_cyc = k;
                sb_addr = wr_addr_out;
            end
        end
        tick(4);
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0;
        sclk_in    = 1'b1;
        serial_in  = 1'b0;
        cs_n_in    = 1'b1;
        step_in    = 1'b0;
        tick(5);
        reset_n_in = 1'b1;
        tick(5);
        n_checks++;
        if (serial_out !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b exp 0", serial_out); end
        n_checks++;
        if (wr_strobe_out !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b exp 0", wr_strobe_out); end
        n_checks++;
        if (wr_addr_out !== 7'h00) begin n_fail++; $display("FAIL reset_addr got %h exp 00", wr_addr_out); end
        n_checks++;
        if ({gconf_out, ihold_irun_out, tpowerdown_out, tpwmthrs_out, chopconf_out, pwmconf_out} !== 192'd0) begin
            n_fail++; $display("FAIL reset_regs got %h %h %h %h %h %h exp all 0", gconf_out, ihold_irun_out,
                               tpowerdown_out, tpwmthrs_out, chopconf_out, pwmconf_out);
        end
    endtask

    task automatic test_read_after_reset();
        spi_frame(40'h0000000000, 40, 0);
        n_checks++;
        if (rx_miso[39:32] !== 8'h01) begin n_fail++; $display("FAIL first_status got %h exp 01", rx_miso[39:32]); end
        spi_frame(40'h0000000000, 40, 0);
        n_checks++;
        if (rx_miso !== 40'h0100000000) begin n_fail++; $display("FAIL second_resp got %h exp 0100000000", rx_miso); end
    endtask

    task automatic test_write_chopconf();
        step_pulse();
        spi_frame(40'hEC000100C3, 40, 0);
        n_checks++;
        if (sb_cnt !== 1 || sb_cyc !== 4 || sb_addr !== 7'h6C) begin
            n_fail++; $display("FAIL chop_strobe got cnt=%0d cyc=%0d addr=%h exp 1/4/6c", sb_cnt, sb_cyc, sb_addr);
        end
        n_checks++;
        if (chopconf_out !== 32'h000100C3) begin n_fail++; $display("FAIL chop_value got %h exp 000100c3", chopconf_out); end
        n_checks++;
        if (wr_addr_out !== 7'h6C) begin n_fail++; $display("FAIL chop_addr got %h exp 6c", wr_addr_out); end
        spi_frame(40'h6C00000000, 40, 0);
        spi_frame(40'h0000000000, 40, 0);
        n_checks++;
        if (rx_miso[31:0] !== 32'h000100C3) begin n_fail++; $display("FAIL chop_read got %h exp 000100c3", rx_miso[31:0]); end
    endtask

    task automatic test_frame_error();
        step_pulse();
        spi_frame(40'h0000000000, 0, 0);          // cs_n pulse without clocks
        spi_frame(40'h0000000000, 40, 0);
        n_checks++;
        if (rx_miso[39:32] !== 8'h03) begin n_fail++; $display("FAIL noclk_status got %h exp 03", rx_miso[39:32]); end
        spi_frame(40'h8100000002, 40, 0);
        n_checks++;
        if (sb_cnt !== 1 || sb_addr !== 7'h01) begin n_fail++; $display("FAIL gstat_strobe got cnt=%0d addr=%h exp 1/01", sb_cnt, sb_addr); end
        spi_frame(40'h0000000000, 40, 0);
        n_checks++;
        if (rx_miso[39:32] !== 8'h01) begin n_fail++; $display("FAIL clr_ferr_status got %h exp 01", rx_miso[39:32]); end
        step_pulse();
        spi_frame(40'h90DEADBEEF, 39, 0);         // short frame
        n_checks++;
        if (sb_cnt !== 0 || ihold_irun_out !== 32'd0) begin
            n_fail++; $display("FAIL short_frame got cnt=%0d ihold=%h exp 0/0", sb_cnt, ihold_irun_out);
        end
        spi_frame(40'h8100000003, 40, 0);
        n_checks++;
        if (rx_miso[39:32] !== 8'h03) begin n_fail++; $display("FAIL short_status got %h exp 03", rx_miso[39:32]); end
        step_pulse();
        spi_frame(40'h0000000000, 40, 0);
        n_checks++;
        if (rx_miso[39:32] !== 8'h00) begin n_fail++; $display("FAIL cleared_status got %h exp 00", rx_miso[39:32]); end
        spi_frame(40'hEC12345678, 41, 0);         // one extra clock
        n_checks++;
        if (sb_cnt !== 0 || chopconf_out !== 32'h000100C3) begin
            n_fail++; $display("FAIL long_frame got cnt=%0d chop=%h exp 0/000100c3", sb_cnt, chopconf_out);
        end
        spi_frame(40'h8100000002, 40, 0);
        n_checks++;
        if (rx_miso[39:32] !== 8'h02) begin n_fail++; $display("FAIL long_status got %h exp 02", rx_miso[39:32]); end
    endtask

    task automatic test_back_to_back();
        spi_frame(40'h8012345678, 40, 0);
        n_checks++;
        if (gconf_out !== 32'h12345678 || sb_addr !== 7'h00 || sb_cnt !== 1) begin
            n_fail++; $display("FAIL gconf_wr got %h addr=%h cnt=%0d exp 12345678/00/1", gconf_out, sb_addr, sb_cnt);
        end
        spi_frame(40'hF0CAFEF00D, 40, 0);
        n_checks++;
        if (pwmconf_out !== 32'hCAFEF00D || sb_addr !== 7'h70) begin
            n_fail++; $display("FAIL pwm_wr got %h addr=%h exp cafef00d/70", pwmconf_out, sb_addr);
        end
        spi_frame(40'h9000071F0A, 40, 0);
        spi_frame(40'h910000000A, 40, 0);
        n_checks++;
        if (ihold_irun_out !== 32'h00071F0A || tpowerdown_out !== 32'h0000000A) begin
            n_fail++; $display("FAIL ihold_tpd got %h %h exp 00071f0a 0000000a", ihold_irun_out, tpowerdown_out);
        end
        spi_frame(40'h85FFFFFFFF, 40, 0);
        n_checks++;
        if (sb_cnt !== 0) begin n_fail++; $display("FAIL unmapped_wr strobes got %0d exp 0", sb_cnt); end
        spi_frame(40'h0000000000, 40, 0);
        spi_frame(40'h7000000000, 40, 0);
        n_checks++;
        if (rx_miso[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL pipe_gconf got %h exp 12345678", rx_miso[31:0]); end
        spi_frame(40'h0500000000, 40, 0);
        n_checks++;
        if (rx_miso[31:0] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL pipe_pwm got %h exp cafef00d", rx_miso[31:0]); end
        spi_frame(40'h0100000000, 40, 0);
        n_checks++;
        if (rx_miso[31:0] !== 32'd0) begin n_fail++; $display("FAIL pipe_unmapped got %h exp 0", rx_miso[31:0]); end
        spi_frame(40'h0000000000, 40, 0);
        n_checks++;
        if (rx_miso[31:0] !== 32'd0) begin n_fail++; $display("FAIL pipe_gstat got %h exp 0", rx_miso[31:0]); end
    endtask

    task automatic test_mscnt();
        for (int p = 0; p < 1025; p++) step_pulse();
        spi_frame(40'hEA00000055, 40, 0);         // read-only: ignored
        n_checks++;
        if (sb_cnt !== 0) begin n_fail++; $display("FAIL mscnt_wr strobes got %0d exp 0", sb_cnt); end
        spi_frame(40'h6A00000000, 40, 0);
        spi_frame(40'h6A00000000, 40, 0);
        exp_ms = 10'(step_model % 1024);
        n_checks++;
        if (rx_miso[31:0] !== {22'd0, exp_ms}) begin
            n_fail++; $display("FAIL mscnt_read got %h exp %h", rx_miso[31:0], {22'd0, exp_ms});
        end
    endtask

    task automatic test_standstill();
        tick(SS + 10);
        spi_frame(40'h0000000000, 40, 0);
        n_checks++;
        if (rx_miso[39:32] !== 8'h08) begin n_fail++; $display("FAIL standstill_set got %h exp 08", rx_miso[39:32]); end
        step_pulse();
        spi_frame(40'h0000000000, 40, 0);
        n_checks++;
        if (rx_miso[39:32] !== 8'h00) begin n_fail++; $display("FAIL standstill_clr got %h exp 00", rx_miso[39:32]); end
    endtask

    task automatic test_reset_midframe();
        step_pulse();
        spi_frame(40'h9300000BAD, 40, 20);
        n_checks++;
        if (tpwmthrs_out !== 32'd0 || sb_cnt !== 0) begin
            n_fail++; $display("FAIL midrst_write got %h cnt=%0d exp 0/0", tpwmthrs_out, sb_cnt);
        end
        n_checks++;
        if (chopconf_out !== 32'd0 || gconf_out !== 32'd0) begin
            n_fail++; $display("FAIL midrst_regs got %h %h exp 0 0", chopconf_out, gconf_out);
        end
        spi_frame(40'h93000001F4, 40, 0);
        n_checks++;
        if (rx_miso[39:32] !== 8'h01) begin n_fail++; $display("FAIL midrst_status got %h exp 01", rx_miso[39:32]); end
        n_checks++;
        if (tpwmthrs_out !== 32'h000001F4 || sb_cyc !== 4 || sb_addr !== 7'h13) begin
            n_fail++; $display("FAIL tpwm_write got %h cyc=%0d addr=%h exp 000001f4/4/13", tpwmthrs_out, sb_cyc, sb_addr);
        end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_chopconf();
        test_frame_error();
        test_back_to_back();
        test_mscnt();
        test_standstill();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmc_spi_responder.md
# tmc_spi_responder

Device-side SPI endpoint emulating the stepper driver's configuration interface. It receives the 40-bit datagrams issued by the motor driver's SPI initiator and writes them into a small register file. It returns the driver-style status byte plus pipelined read data, and counts step pulses into a microstep counter. It is used as the in-FPGA stand-in for the external driver in loopback builds and benches.

## Interface
- STANDSTILL_CYCLES, default 1000000: clk_in cycles without a step rising edge before the standstill flag sets.
- clk_in  input  1  system clock; the only clock.
- reset_n_in  input  1  asynchronous, active-low reset.
- sclk_in  input  1  SPI clock from the initiator, asynchronous, idles high.
- serial_in  input  1  MOSI.
- cs_n_in  input  1  chip select, active low.
- step_in  input  1  step pulse from the initiator, asynchronous.
- serial_out  output  1  MISO; drives 0 while cs_n is high.
- gconf_out, ihold_irun_out, tpowerdown_out, tpwmthrs_out, chopconf_out, pwmconf_out  output  32 each  current register contents.
- wr_strobe_out  output  1  one-cycle pulse per committed write.
- wr_addr_out  output  7  address of the last committed write.

## Operation
- sclk_in, serial_in, cs_n_in and step_in each pass through a 2-flop synchronizer, then edge detection on clk_in.
- SPI mode 3: MOSI sampled on sclk rising; MISO updated on sclk falling; MSB first; 40 bits per frame.
- Frame format in: bit 39 is the write flag, 38:32 the address, 31:0 the data.
- Frame format out: 39:32 status byte, 31:0 read buffer (data selected by the previous read frame).
- FSM states:
  - IDLE: on cs_n fall, load tx = {status, read_buf}, clear bit_cnt, go to SHIFT.
  - SHIFT:
    - On sclk rise: rx <= {rx[38:0], mosi}; bit_cnt saturates at 41.
    - On sclk fall with bit_cnt != 0: tx shifts left.
    - On cs_n rise, go to COMMIT.
  - COMMIT, one cycle, then IDLE:
    - If bit_cnt == 40 and write: write register, set wr_strobe_out and wr_addr_out.
    - If bit_cnt == 40 and read: read_buf <= addressed value.
    - If bit_cnt != 40: discard the frame and set GSTAT.frame_err.
- Register map (7-bit address):
  - 0x00 GCONF.
  - 0x01 GSTAT: bit0 reset, bit1 frame_err; write-1-to-clear; reads 0x00000000 | flags.
  - 0x10 IHOLD_IRUN.
  - 0x11 TPOWERDOWN.
  - 0x13 TPWMTHRS.
  - 0x6A MSCNT: read-only, 10-bit, zero-extended.
  - 0x6C CHOPCONF.
  - 0x70 PWMCONF.
  - Writes to other addresses and to 0x6A are ignored and produce no strobe.
  - Reads of unmapped addresses return 0.
- All writable registers store the full 32 bits.
- Status byte: bit0 = GSTAT.reset, bit1 = GSTAT.frame_err, bit3 = standstill; all other bits 0.
- MSCNT increments on each synchronized step_in rising edge, wrapping 1023 -> 0.
- Idle counter: cleared on each step edge, saturates at STANDSTILL_CYCLES; standstill = (idle counter == STANDSTILL_CYCLES).
- Write and read buffer update in the same COMMIT cycle; the status is sampled at the next cs_n fall.

## Timing
- Reset values:
  - All registers, MSCNT, read_buf and idle counter are 0.
  - GSTAT.reset = 1, frame_err = 0.
  - serial_out = 0, wr_strobe_out = 0, wr_addr_out = 0; FSM in IDLE.
- sclk_in high and low phases must each be at least 4 clk_in cycles. cs_n setup to the first sclk fall must be at least 4 clk_in cycles.
- serial_out shows tx[39] 3 clk_in cycles after cs_n fall, and each new bit 3 cycles after sclk fall.
- Register outputs and wr_strobe_out update 4 clk_in cycles after the cs_n rise (2 sync, 1 edge detect, 1 COMMIT).
- A cs_n rise with no sclk edges sets frame_err.
- Extra clocks beyond 40 set frame_err.
- Reset asserted mid-frame:
  - Immediate return to IDLE; registers take their reset values.
  - The remainder of the frame is ignored until the next cs_n fall.
- A step edge coinciding with an MSCNT read: read_buf captures the pre-increment value.

## Test plan
- Reset, send read 40'h0000000000 twice -> first response byte 0x01, second response data 0x00000000.
- Write 40'hEC000100C3 -> chopconf_out = 0x000100C3 four cycles after cs_n rise, one-cycle wr_strobe_out with wr_addr_out = 0x6C. Then read 0x6C followed by any frame -> second response data 0x000100C3.
- 39-clock frame carrying a write to 0x10 -> ihold_irun_out unchanged, no strobe, next response status bit1 = 1. Write 40'h8100000003 -> next status byte 0x00 (step idle not elapsed).
- 1025 step_in pulses, then read 0x6A twice -> data 0x00000001.
- No steps for STANDSTILL_CYCLES+10 -> status bit3 = 1. One step -> bit3 = 0 on the next frame.
- Write to 0x13 with reset pulsed after bit 20 -> tpwmthrs_out = 0, GSTAT.reset = 1. A following full write of 40'h93000001F4 -> tpwmthrs_out = 0x000001F4.
